decoder_3x8_hs: RTL and testbench

// - Registered binary-to-one-hot decoder with valid/ready handshakes; the inverse of the 8x3 encoder path.
// - Takes an IN_W-bit code and presents the matching one-hot word.
// - Each word is held for at least HOLD_CYCLES cycles before the downstream can retire it.
// - Sits between the code-producing logic and one-hot consumers such as select lines or LED banks; absorbs backpressure through a one-entry skid buffer.

---
 rtl/codec_pkg.sv | 29 ++
 rtl/skid_buffer_1.sv | 46 ++++
 rtl/decoder_3x8_hs.sv | 116 +++++++++++
 tb/tb_decoder_3x8_hs.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared definitions for the binary/one-hot codec blocks: output-stage states,
// the word carried through the skid, and the decode function the checkers reuse.
package codec_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 1 << CODE_W;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HOLD    = 2'd1,
        PRESENT = 2'd2
    } state_e;

    typedef struct packed {
        logic              en;
        logic [CODE_W-1:0] code;
    } word_t;

    function automatic logic [ONEHOT_W-1:0] onehot_of(input logic [CODE_W-1:0] code,
                                                      input logic              en);
        logic [ONEHOT_W-1:0] oh;
        oh = '0;
        if (en) begin
            oh[code] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/skid_buffer_1.sv
// One-entry skid register holding a word the output stage could not take.
// Latency: a pushed word is available on pop_dat the cycle after the push.
// Backpressure: rdy is registered, low exactly while the entry is occupied.
module skid_buffer_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_dat,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         rdy
);

    logic         full_q, full_d;
    logic [W-1:0] dat_q, dat_d;

    // push and pop never coincide: a push needs rdy, which implies empty
    always_comb begin
        full_d = full_q;
        dat_d  = dat_q;
        if (push) begin
            full_d = 1'b1;
            dat_d  = push_dat;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
        end
    end

    assign pop_dat = dat_q;
    assign full    = full_q;
    assign rdy     = !full_q;

endmodule

// File: rtl/decoder_3x8_hs.sv
// Registered binary-to-one-hot decoder with a minimum per-word hold time.
// Latency: one cycle from input transfer to out_valid when the output stage is free.
// Backpressure: a one-entry skid absorbs a stalled word; in_ready is registered.
module decoder_3x8_hs
    import codec_pkg::*;
#(
    parameter int IN_W        = CODE_W,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
    input  logic                 in_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [(1<<IN_W)-1:0] out_onehot,
    output logic [IN_W-1:0]      out_code,
    output logic                 busy
);

    localparam int OUT_W = 1 << IN_W;
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("decoder_3x8_hs: HOLD_CYCLES must be within 1..255");
    end
    if (IN_W != CODE_W) begin : g_bad_width
        $error("decoder_3x8_hs: IN_W must match codec_pkg::CODE_W");
    end

    state_e           state_q, state_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [OUT_W-1:0] onehot_q, onehot_d;
    logic [IN_W-1:0]  code_q, code_d;

    word_t in_word, skid_word, load_word;
    logic  skid_full, skid_rdy, skid_push;
    logic  in_xfer, retire, out_free, load, load_skid;

    assign in_word = '{en: in_en, code: in_code};

    skid_buffer_1 #(.W($bits(word_t))) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (skid_push),
        .pop      (load_skid),
        .push_dat (in_word),
        .pop_dat  (skid_word),
        .full     (skid_full),
        .rdy      (skid_rdy)
    );

    // The skid always wins over a fresh input so word order is preserved.
    always_comb begin
        in_xfer   = in_valid & skid_rdy;
        retire    = (state_q == PRESENT) & out_ready;
        out_free  = (state_q == EMPTY) | retire;
        load_skid = out_free & skid_full;
        load      = load_skid | (out_free & in_xfer);
        skid_push = in_xfer & ~out_free;
        load_word = load_skid ? skid_word : in_word;
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        onehot_d   = onehot_q;
        code_d     = code_q;
        case (state_q)
            EMPTY: ;
            HOLD: begin
                hold_cnt_d = hold_cnt_q - 8'd1;
                if (hold_cnt_q == 8'd1) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    state_d  = EMPTY;
                    onehot_d = '0;
                    code_d   = '0;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) begin
            state_d    = (HOLD_CYCLES > 1) ? HOLD : PRESENT;
            hold_cnt_d = HOLD_LOAD;
            onehot_d   = onehot_of(load_word.code, load_word.en);
            code_d     = load_word.code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            hold_cnt_q <= 8'd0;
            onehot_q   <= '0;
            code_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            onehot_q   <= onehot_d;
            code_q     <= code_d;
        end
    end

    assign in_ready   = skid_rdy;
    assign out_valid  = (state_q != EMPTY);
    assign out_onehot = onehot_q;
    assign out_code   = code_q;
    assign busy       = (state_q != EMPTY) | skid_full;

endmodule

// File: tb/tb_decoder_3x8_hs.sv
// Scoreboard bench: stimulus queues hand-computed words, a monitor retires them
// against the DUT output; a second instance covers the multi-cycle hold path.
module tb_decoder_3x8_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_en, out_valid, out_ready, busy;
    logic [2:0] in_code, out_code;
    logic [7:0] out_onehot;

    logic       in_valid4, in_ready4, in_en4, out_valid4, out_ready4, busy4;
    logic [2:0] in_code4, out_code4;
    logic [7:0] out_onehot4;

    typedef struct packed {
        logic [7:0] oh;
        logic [2:0] code;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   pops   = 0;

    always #5 clk = ~clk;

    decoder_3x8_hs #(.IN_W(3), .HOLD_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_en(in_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
        .out_code(out_code), .busy(busy)
    );

    decoder_3x8_hs #(.IN_W(3), .HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_code(in_code4), .in_en(in_en4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_onehot(out_onehot4),
        .out_code(out_code4), .busy(busy4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send(input logic [2:0] c, input logic e, input logic [7:0] exp_oh);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_code  = c;
        in_en    = e;
        sb_q.push_back('{oh: exp_oh, code: c});
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL send_timeout: in_ready stayed 0 for code %0d", c);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_extra: unexpected word onehot=%0h code=%0d", out_onehot, out_code);
            end else begin
                e = sb_q.pop_front();
                check("sb_onehot", {24'd0, out_onehot}, {24'd0, e.oh});
                check("sb_code", {29'd0, out_code}, {29'd0, e.code});
                pops++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] oh_tab [8];
        int         pops0, cnt;
        logic       ok;
        oh_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        rst = 1'b1;
        in_valid = 0; in_code = 0; in_en = 0; out_ready = 0;
        in_valid4 = 0; in_code4 = 0; in_en4 = 0; out_ready4 = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_onehot", out_onehot, 8'h00);
        check("rst_out_code", out_code, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);

        // Back-to-back codes 0..7, one word per cycle
        @(posedge clk); #1 out_ready = 1'b1;
        pops0 = pops;
        for (int i = 0; i < 8; i++) send(3'(i), 1'b1, oh_tab[i]);
        @(negedge clk); #1;
        check("b2b_no_bubble_pops", pops - pops0, 8);
        @(negedge clk);
        check("b2b_drained_valid", out_valid, 0);

        // Disabled decode still echoes the code
        @(posedge clk); #1;
        send(3'd5, 1'b0, 8'h00);
        repeat (2) @(negedge clk);

        // Backpressure: 2 in output, 6 in skid, 1 waiting
        @(posedge clk); #1 out_ready = 1'b0;
        pops0 = pops;
        send(3'd2, 1'b1, 8'h04);
        send(3'd6, 1'b1, 8'h40);
        in_valid = 1'b1; in_code = 3'd1; in_en = 1'b1;
        sb_q.push_back('{oh: 8'h02, code: 3'd1});
        @(negedge clk);
        check("bp_out_valid", out_valid, 1);
        check("bp_out_onehot", out_onehot, 8'h04);
        check("bp_out_code", out_code, 2);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_busy", busy, 1);
        repeat (2) @(negedge clk);
        check("bp_stable_onehot", out_onehot, 8'h04);
        @(posedge clk); #1 out_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_in_ready_rises", ok, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_pops", pops - pops0, 3);
        check("bp_sb_empty", sb_q.size(), 0);

        // Reset with the output and skid both occupied
        @(posedge clk); #1 out_ready = 1'b0;
        send(3'd3, 1'b1, 8'h08);
        send(3'd4, 1'b1, 8'h10);
        sb_q.delete();
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_in_ready", in_ready, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_onehot", out_onehot, 8'h00);
        check("mid_rst_out_code", out_code, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        pops0 = pops;
        send(3'd7, 1'b1, 8'h80);
        repeat (3) @(negedge clk);
        check("post_rst_pops", pops - pops0, 1);
        check("post_rst_sb_empty", sb_q.size(), 0);

        // HOLD_CYCLES=4 instance: code 3 visible exactly four cycles
        @(posedge clk); #1;
        in_valid4 = 1'b1; in_code4 = 3'd3; in_en4 = 1'b1;
        @(posedge clk); #1 in_valid4 = 1'b0;
        cnt = 0;
        @(negedge clk);
        check("hold4_latency_valid", out_valid4, 1);
        if (out_valid4) cnt++;
        for (int k = 0; k < 7; k++) begin
            if (out_valid4) begin
                check("hold4_onehot", out_onehot4, 8'h08);
                check("hold4_code", out_code4, 3);
            end
            @(negedge clk);
            if (out_valid4) cnt++;
        end
        check("hold4_valid_cycles", cnt, 4);
        check("hold4_busy_after", busy4, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
